// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS data-side memory stage: MMIO offsets,
// MEM control bit positions and serial transmitter state encoding.
package mips_mem_pkg;

  localparam logic [31:0] MMIO_LED = 32'h0000_0000;
  localparam logic [31:0] MMIO_SW  = 32'h0000_0004;
  localparam logic [31:0] MMIO_CNT = 32'h0000_0008;
  localparam logic [31:0] MMIO_TXD = 32'h0000_000C;
  localparam logic [31:0] MMIO_TXS = 32'h0000_0010;

  localparam int MEM_RD = 2;
  localparam int MEM_WR = 1;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/mmio_uart_tx.sv
// Byte-wide serial transmitter: one start bit, eight data bits LSB first,
// one stop bit, each held for BAUD_DIV clocks. Start requests while busy are ignored.
module mmio_uart_tx
  import mips_mem_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] RELOAD = BW'(BAUD_DIV - 1);

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other, matching real flip-flop behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            state    <= TX_START;
            baud_cnt <= RELOAD;
            shreg    <= data;
          end
        end
        TX_START: begin
          if (baud_cnt == '0) begin
            state    <= TX_DATA;
            baud_cnt <= RELOAD;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= RELOAD;
            if (bit_idx == 3'd7) state <= TX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          if (baud_cnt == '0) state    <= TX_IDLE;
          else                baud_cnt <= baud_cnt - 1'b1;
        end
      endcase
    end
  end

  // Line level is a pure function of state so it changes exactly at the edge.
  always_comb begin
    tx = 1'b1;
    case (state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shreg[bit_idx];
      default:  tx = 1'b1;
    endcase
  end

  assign busy = (state != TX_IDLE);

endmodule

// File: rtl/mips_data_mem_mmio.sv
// MEM-stage data memory for the pipelined MIPS core: word RAM with
// combinational loads plus an I/O window (LEDs, switches, counter, serial TX).
module mips_data_mem_mmio
  import mips_mem_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_FF00,
  parameter int          BAUD_DIV  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAddr,
  input  logic [31:0] DataOut,
  input  logic [3:0]  MemCtl,
  output logic [31:0] DataIn,
  input  logic [7:0]  Switches,
  output logic [7:0]  Leds,
  output logic        TxLine,
  output logic        AccessErr
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      cnt;
  logic [31:0]      mmio_off;
  logic [31:0]      mmio_rdata;
  logic [IDX_W-1:0] ram_idx;
  logic rd, wr, aligned, in_ram, in_mmio, mapped;
  logic ram_we, mmio_we, tx_busy;
  logic unused_memctl;

  assign rd            = MemCtl[MEM_RD];
  assign wr            = MemCtl[MEM_WR];
  assign unused_memctl = MemCtl[3] ^ MemCtl[0];

  assign aligned  = (DataAddr[1:0] == 2'b00);
  assign in_ram   = (DataAddr < RAM_BYTES);
  assign mmio_off = DataAddr - MMIO_BASE;
  assign in_mmio  = (DataAddr >= MMIO_BASE) && (mmio_off <= MMIO_TXS);
  assign mapped   = aligned && (in_ram || in_mmio);
  assign ram_idx  = DataAddr[IDX_W+1:2];

  // A write with a bad address is suppressed entirely; RAM wins any overlap.
  assign ram_we  = wr && mapped && in_ram;
  assign mmio_we = wr && mapped && !in_ram;

  // NOTE: the RAM array has no reset branch; clearing it would turn the
  // storage into a huge bank of resettable flops instead of a memory.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= DataOut;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Leds      <= '0;
      cnt       <= '0;
      AccessErr <= 1'b0;
    end else begin
      if (mmio_we && mmio_off == MMIO_LED) Leds <= DataOut[7:0];
      if (mmio_we && mmio_off == MMIO_CNT) cnt <= '0;
      else                                 cnt <= cnt + 32'd1;
      if ((rd || wr) && !mapped)           AccessErr <= 1'b1;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      MMIO_LED: mmio_rdata = {24'b0, Leds};
      MMIO_SW:  mmio_rdata = {24'b0, Switches};
      MMIO_CNT: mmio_rdata = cnt;
      MMIO_TXS: mmio_rdata = {31'b0, tx_busy};
      default:  mmio_rdata = '0;
    endcase
  end

  always_comb begin
    DataIn = '0;
    if (rd && mapped) DataIn = in_ram ? ram[ram_idx] : mmio_rdata;
  end

  mmio_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .start(mmio_we && mmio_off == MMIO_TXD),
    .data (DataOut[7:0]),
    .busy (tx_busy),
    .tx   (TxLine)
  );

endmodule

// File: tb/tb_mips_data_mem_mmio.sv
// Randomized bench for mips_data_mem_mmio against a cycle-level behavioural
// model of the memory map, counter and serial frame timing.
module tb_mips_data_mem_mmio;

  localparam int          B     = 4;
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam int          WORDS = 256;
  localparam logic [3:0]  RD    = 4'b0100;
  localparam logic [3:0]  WR    = 4'b0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] DataAddr = '0, DataOut = '0, DataIn;
  logic [3:0]  MemCtl = '0;
  logic [7:0]  Switches = '0, Leds;
  logic        TxLine, AccessErr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_mem [int];
  logic [7:0]  m_leds;
  logic [31:0] m_cnt;
  bit          m_err;
  bit          m_tx_on;
  int          m_tx_k;
  logic [7:0]  m_tx_byte;

  logic [31:0] e_din;
  bit          e_din_known;
  logic        e_tx, e_busy;

  mips_data_mem_mmio #(
    .RAM_WORDS(WORDS),
    .MMIO_BASE(BASE),
    .BAUD_DIV (B)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .DataAddr (DataAddr),
    .DataOut  (DataOut),
    .MemCtl   (MemCtl),
    .DataIn   (DataIn),
    .Switches (Switches),
    .Leds     (Leds),
    .TxLine   (TxLine),
    .AccessErr(AccessErr)
  );

  always #5 clk = ~clk;

  // -1 = error access, 0 = RAM, 1 = MMIO
  function automatic int region(input logic [31:0] a);
    if (a % 4 != 0) return -1;
    if (a < WORDS * 4) return 0;
    if (a >= BASE && a <= BASE + 16) return 1;
    return -1;
  endfunction

  function automatic logic model_busy();
    return m_tx_on && (m_tx_k < 10 * B);
  endfunction

  // Frame as seen on the wire k cycles after the accepting edge.
  function automatic logic model_line();
    if (!model_busy()) return 1'b1;
    if (m_tx_k < B) return 1'b0;
    if (m_tx_k < 9 * B) return m_tx_byte[(m_tx_k - B) / B];
    return 1'b1;
  endfunction

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] ctl);
    @(negedge clk);
    DataAddr = addr;
    DataOut  = wdata;
    MemCtl   = ctl;
    #1;
    e_tx        = model_line();
    e_busy      = model_busy();
    e_din       = '0;
    e_din_known = 1'b1;
    if (ctl[2]) begin
      if (region(addr) == 0) begin
        if (m_mem.exists(int'(addr >> 2))) e_din = m_mem[int'(addr >> 2)];
        else e_din_known = 1'b0;
      end else if (region(addr) == 1) begin
        case ((addr - BASE) / 4)
          0: e_din = {24'b0, m_leds};
          1: e_din = {24'b0, Switches};
          2: e_din = m_cnt;
          4: e_din = {31'b0, e_busy};
          default: e_din = '0;
        endcase
      end
    end
  endtask

  task automatic tick();
    int  r;
    bit  clr, go;
    @(posedge clk);
    r   = region(DataAddr);
    clr = 1'b0;
    go  = 1'b0;
    if ((MemCtl[2] || MemCtl[1]) && r < 0) m_err = 1'b1;
    if (MemCtl[1] && r == 0) m_mem[int'(DataAddr >> 2)] = DataOut;
    if (MemCtl[1] && r == 1) begin
      case ((DataAddr - BASE) / 4)
        0: m_leds = DataOut[7:0];
        2: clr = 1'b1;
        3: go = !model_busy();
        default: ;
      endcase
    end
    m_cnt = clr ? 32'd0 : m_cnt + 32'd1;
    if (go) begin
      m_tx_on   = 1'b1;
      m_tx_k    = 0;
      m_tx_byte = DataOut[7:0];
    end else if (m_tx_on) begin
      m_tx_k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    MemCtl = '0;
    @(posedge clk);
    m_leds  = '0;
    m_cnt   = '0;
    m_err   = 1'b0;
    m_tx_on = 1'b0;
    m_tx_k  = 0;
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(32'h0, 32'h0, 4'b0000);
    n_cmp += 4;
    if (Leds !== 8'h00) begin n_bad++; $display("FAIL reset_leds got %h want 00", Leds); end
    if (AccessErr !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", AccessErr); end
    if (TxLine !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", TxLine); end
    if (DataIn !== 32'h0) begin n_bad++; $display("FAIL reset_din got %h want 0", DataIn); end
    tick();
    repeat (4) begin drive(32'h0, 32'h0, 4'b0000); tick(); end
    drive(BASE + 8, 32'h0, RD);
    n_cmp++;
    if (DataIn !== 32'd5) begin n_bad++; $display("FAIL reset_cnt5 got %0d want 5", DataIn); end
    tick();
  endtask

  task automatic test_ram();
    drive(32'h10, 32'h1111_2222, WR); tick();
    drive(32'h10, 32'hDEAD_BEEF, RD | WR);
    n_cmp++;
    if (DataIn !== 32'h1111_2222) begin n_bad++; $display("FAIL ram_same_cycle got %h want 11112222", DataIn); end
    tick();
    drive(32'h10, 32'h0, RD);
    n_cmp++;
    if (DataIn !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_load got %h want deadbeef", DataIn); end
    tick();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ctl;
      case ($urandom_range(0, 2))
        0: ctl = RD;
        1: ctl = WR;
        default: ctl = RD | WR;
      endcase
      drive(32'h40 + 4 * $urandom_range(0, 7), $urandom, ctl);
      if (e_din_known) begin
        n_cmp++;
        if (DataIn !== e_din) begin n_bad++; $display("FAIL ram_rand addr=%h got %h want %h", DataAddr, DataIn, e_din); end
      end
      tick();
    end
  endtask

  task automatic test_led_sw();
    Switches = 8'h3C;
    drive(BASE, 32'h1A5, WR); tick();
    drive(BASE + 4, 32'hFF, RD | WR);
    n_cmp += 3;
    if (Leds !== 8'hA5) begin n_bad++; $display("FAIL led_write got %h want a5", Leds); end
    if (DataIn !== 32'h0000_003C) begin n_bad++; $display("FAIL sw_read got %h want 3c", DataIn); end
    if (AccessErr !== 1'b0) begin n_bad++; $display("FAIL sw_ro_write_err got %b want 0", AccessErr); end
    tick();
    drive(BASE, 32'h0, RD);
    n_cmp++;
    if (DataIn !== 32'h0000_00A5) begin n_bad++; $display("FAIL led_read got %h want a5", DataIn); end
    tick();
    for (int i = 0; i < 8; i++) begin
      Switches = 8'($urandom);
      drive(BASE + 4 * $urandom_range(0, 1), $urandom, (i % 2 == 0) ? RD : (RD | WR));
      n_cmp += 2;
      if (DataIn !== e_din) begin n_bad++; $display("FAIL ledsw_rand addr=%h got %h want %h", DataAddr, DataIn, e_din); end
      if (Leds !== m_leds) begin n_bad++; $display("FAIL ledsw_leds got %h want %h", Leds, m_leds); end
      tick();
    end
  endtask

  task automatic test_counter();
    drive(BASE + 8, $urandom, WR); tick();
    drive(32'h0, 32'h0, 4'b0000); tick();
    drive(BASE + 8, 32'h0, RD);
    n_cmp++;
    if (DataIn !== 32'd1) begin n_bad++; $display("FAIL cnt_clear got %0d want 1", DataIn); end
    tick();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 6)) begin drive(32'h0, 32'h0, 4'b0000); tick(); end
      drive(BASE + 8, 32'h0, RD);
      n_cmp++;
      if (DataIn !== e_din) begin n_bad++; $display("FAIL cnt_rand got %0d want %0d", DataIn, e_din); end
      tick();
    end
  endtask

  task automatic run_frame_checks(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      drive(BASE + 16, 32'h0, RD);
      n_cmp += 2;
      if (TxLine !== e_tx) begin n_bad++; $display("FAIL %s_line cyc=%0d got %b want %b", tag, i, TxLine, e_tx); end
      if (DataIn !== e_din) begin n_bad++; $display("FAIL %s_busy cyc=%0d got %h want %h", tag, i, DataIn, e_din); end
      tick();
    end
  endtask

  task automatic test_uart();
    logic line [40];
    logic want;
    drive(BASE + 12, 32'h55, WR);
    n_cmp++;
    if (TxLine !== 1'b1) begin n_bad++; $display("FAIL uart_pre_line got %b want 1", TxLine); end
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i == 10) drive(BASE + 12, 32'hFF, RD | WR);
      else         drive(BASE + 16, 32'h0, RD);
      line[i] = TxLine;
      n_cmp++;
      if (DataIn !== ((i == 10) ? 32'h0 : 32'h1)) begin n_bad++; $display("FAIL uart_busy cyc=%0d got %h", i, DataIn); end
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       want = 1'b0;
      else if (i < 36) want = ((i / 4) % 2 == 1);
      else             want = 1'b1;
      n_cmp++;
      if (line[i] !== want) begin n_bad++; $display("FAIL uart_frame55 cyc=%0d got %b want %b", i, line[i], want); end
    end
    drive(BASE + 12, 32'hA3, RD | WR);
    n_cmp += 2;
    if (TxLine !== 1'b1) begin n_bad++; $display("FAIL uart_idle_line got %b want 1", TxLine); end
    if (DataIn !== 32'h0) begin n_bad++; $display("FAIL uart_txd_read got %h want 0", DataIn); end
    tick();
    run_frame_checks(42, "uart_a3");
  endtask

  task automatic test_errors();
    drive(32'h11, 32'h1234_5678, WR);
    n_cmp++;
    if (AccessErr !== 1'b0) begin n_bad++; $display("FAIL err_before_edge got %b want 0", AccessErr); end
    tick();
    drive(32'h10, 32'h0, RD);
    n_cmp += 2;
    if (DataIn !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL err_ram_kept got %h want deadbeef", DataIn); end
    if (AccessErr !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", AccessErr); end
    tick();
    drive(32'h8000, 32'h0, RD);
    n_cmp++;
    if (DataIn !== 32'h0) begin n_bad++; $display("FAIL err_unmapped_din got %h want 0", DataIn); end
    tick();
    drive(BASE + 2, 32'h0, RD);
    n_cmp++;
    if (DataIn !== 32'h0) begin n_bad++; $display("FAIL err_misaligned_mmio got %h want 0", DataIn); end
    tick();
    repeat (3) begin drive(32'h0, 32'h0, 4'b0000); tick(); end
    drive(32'h0, 32'h0, 4'b0000);
    n_cmp++;
    if (AccessErr !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", AccessErr); end
    tick();
    do_reset();
    drive(32'h0, 32'h0, 4'b0000);
    n_cmp++;
    if (AccessErr !== 1'b0) begin n_bad++; $display("FAIL err_reset got %b want 0", AccessErr); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    drive(BASE + 12, 32'h96, WR); tick();
    repeat (12) begin drive(32'h0, 32'h0, 4'b0000); tick(); end
    do_reset();
    drive(BASE + 16, 32'h0, RD);
    n_cmp += 2;
    if (TxLine !== 1'b1) begin n_bad++; $display("FAIL midrst_line got %b want 1", TxLine); end
    if (DataIn !== 32'h0) begin n_bad++; $display("FAIL midrst_busy got %h want 0", DataIn); end
    tick();
    drive(BASE + 12, 32'h3C, WR); tick();
    run_frame_checks(42, "midrst_frame");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1: a = 32'h80 + 4 * $urandom_range(0, 7);
        2, 3: a = BASE + 4 * $urandom_range(0, 4);
        4:    a = 32'h80 + $urandom_range(0, 31);
        default: a = ($urandom_range(0, 1) == 1) ? BASE + 20 : 32'h0001_0000;
      endcase
      Switches = 8'($urandom);
      drive(a, $urandom, 4'($urandom));
      n_cmp += 3;
      if (e_din_known) begin
        n_cmp++;
        if (DataIn !== e_din) begin n_bad++; $display("FAIL rand_din addr=%h ctl=%b got %h want %h", a, MemCtl, DataIn, e_din); end
      end
      if (TxLine !== e_tx) begin n_bad++; $display("FAIL rand_line cyc=%0d got %b want %b", i, TxLine, e_tx); end
      if (Leds !== m_leds) begin n_bad++; $display("FAIL rand_leds cyc=%0d got %h want %h", i, Leds, m_leds); end
      if (AccessErr !== m_err) begin n_bad++; $display("FAIL rand_err cyc=%0d got %b want %b", i, AccessErr, m_err); end
      tick();
      if (i % 100 == 99) do_reset();
    end
  endtask

  initial begin
    m_leds = '0; m_cnt = '0; m_err = 1'b0; m_tx_on = 1'b0; m_tx_k = 0; m_tx_byte = '0;
    test_reset();
    test_ram();
    test_led_sw();
    test_counter();
    test_uart();
    test_errors();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
